// File: rtl/conflict_table.sv
// conflict_table: small fully-associative table that maps string keys to
// {hash, map} code pairs.
//
// Lookup is combinational. A write either updates the codes of an entry that
// already holds the key, or fills the lowest free entry. Entries are freed
// only by reset.
//
// Ports
//   clk       rising-edge clock
//   rst       asynchronous active-high reset; clears the whole table
//   cs        chip select; gates both lookup and write
//   we        write enable (qualified by cs)
//   data      search key, and the key stored on a write
//   hash_in   hash code stored on a write
//   map_in    map code stored on a write
//   match     key hit (cs and a valid entry holds data)
//   hash_out  hash code of the lowest-index hit entry, else 0
//   map_out   map code of the lowest-index hit entry, else 0
//   ct_full   all DEPTH entries are valid
module conflict_table #(
  parameter int unsigned DEPTH      = 8,
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned HASH_WIDTH = 11
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cs,
  input  logic                  we,
  input  logic [DATA_WIDTH-1:0] data,
  input  logic [HASH_WIDTH-1:0] hash_in,
  input  logic [HASH_WIDTH-1:0] map_in,
  output logic                  match,
  output logic [HASH_WIDTH-1:0] hash_out,
  output logic [HASH_WIDTH-1:0] map_out,
  output logic                  ct_full
);

  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned IW = $clog2(DEPTH);

  logic                  valid_q [DEPTH];
  logic [DATA_WIDTH-1:0] key_q   [DEPTH];
  logic [HASH_WIDTH-1:0] hash_q  [DEPTH];
  logic [HASH_WIDTH-1:0] map_q   [DEPTH];
  logic [CW-1:0]         count_q;

  logic          hit_any;
  logic [IW-1:0] hit_idx;
  logic          free_any;
  logic [IW-1:0] free_idx;

  // Priority search from index 0 upward: the first hit and the first free
  // slot win.
  always_comb begin
    hit_any  = 1'b0;
    hit_idx  = '0;
    free_any = 1'b0;
    free_idx = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (!hit_any && valid_q[i] && (key_q[i] == data)) begin
        hit_any = 1'b1;
        hit_idx = IW'(i);
      end
      if (!free_any && !valid_q[i]) begin
        free_any = 1'b1;
        free_idx = IW'(i);
      end
    end
  end

  assign match    = cs & hit_any;
  assign hash_out = match ? hash_q[hit_idx] : '0;
  assign map_out  = match ? map_q[hit_idx]  : '0;
  assign ct_full  = (count_q == CW'(DEPTH));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        valid_q[i] <= 1'b0;
        key_q[i]   <= '0;
        hash_q[i]  <= '0;
        map_q[i]   <= '0;
      end
      count_q <= '0;
    end else if (cs && we) begin
      if (hit_any) begin
        // Existing key: refresh codes in place, no allocation.
        hash_q[hit_idx] <= hash_in;
        map_q[hit_idx]  <= map_in;
      end else if (free_any) begin
        // A free slot exists exactly when the table is not full.
        valid_q[free_idx] <= 1'b1;
        key_q[free_idx]   <= data;
        hash_q[free_idx]  <= hash_in;
        map_q[free_idx]   <= map_in;
        count_q           <= count_q + CW'(1);
      end
    end
  end

endmodule

// File: tb/tb_conflict_table.sv
module tb_conflict_table;

  logic        clk = 1'b0;
  logic        rst;
  logic        cs;
  logic        we;
  logic [63:0] data;
  logic [10:0] hash_in;
  logic [10:0] map_in;
  logic        match;
  logic [10:0] hash_out;
  logic [10:0] map_out;
  logic        ct_full;

  conflict_table #(.DEPTH(8), .DATA_WIDTH(64), .HASH_WIDTH(11)) dut (
    .clk      (clk),
    .rst      (rst),
    .cs       (cs),
    .we       (we),
    .data     (data),
    .hash_in  (hash_in),
    .map_in   (map_in),
    .match    (match),
    .hash_out (hash_out),
    .map_out  (map_out),
    .ct_full  (ct_full)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        m;
    logic [10:0] h;
    logic [10:0] mp;
    logic        f;
  } exp_t;

  exp_t sb[$];
  int   n_chk  = 0;
  int   n_fail = 0;

  // Monitor: outputs are sampled on the falling edge, away from the write edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        n_chk++;
        if ({match, hash_out, map_out, ct_full} !== {e.m, e.h, e.mp, e.f}) begin
          n_fail++;
          $display("FAIL %s: got match=%b hash=%h map=%h full=%b, expected match=%b hash=%h map=%h full=%b",
                   e.name, match, hash_out, map_out, ct_full, e.m, e.h, e.mp, e.f);
        end
      end
    end
  end

  task automatic push(input string name, input logic m, input logic [10:0] h,
                      input logic [10:0] mp, input logic f);
    exp_t e;
    e.name = name; e.m = m; e.h = h; e.mp = mp; e.f = f;
    sb.push_back(e);
  endtask

  // Drive one cycle of stimulus just after the rising edge and queue the
  // response expected before the next edge.
  task automatic cyc(input string name, input logic c, input logic w,
                     input logic [63:0] d, input logic [10:0] hi, input logic [10:0] mi,
                     input logic m, input logic [10:0] h, input logic [10:0] mp,
                     input logic f);
    @(posedge clk);
    #1;
    cs = c; we = w; data = d; hash_in = hi; map_in = mi;
    push(name, m, h, mp, f);
  endtask

  initial begin
    rst = 1'b1; cs = 1'b0; we = 1'b0; data = '0; hash_in = '0; map_in = '0;

    // Writes while reset is held are ignored.
    cyc("rst_write",   1, 1, 64'h99, 11'h1, 11'h2, 0, 11'h0, 11'h0, 0);
    cyc("rst_hold",    1, 0, 64'h99, 11'h0, 11'h0, 0, 11'h0, 11'h0, 0);
    rst = 1'b0;
    cyc("rst_miss",    1, 0, 64'h99, 11'h0, 11'h0, 0, 11'h0, 11'h0, 0);
    cyc("reset_state", 1, 0, 64'h41, 11'h0, 11'h0, 0, 11'h0, 11'h0, 0);

    // Basic write; same-cycle lookup sees pre-edge contents.
    cyc("wr_4241",     1, 1, 64'h4241, 11'h123, 11'h105, 0, 11'h0, 11'h0, 0);
    cyc("hit_4241",    1, 0, 64'h4241, 11'h0, 11'h0, 1, 11'h123, 11'h105, 0);
    cyc("miss_4242",   1, 0, 64'h4242, 11'h0, 11'h0, 0, 11'h0, 11'h0, 0);

    // Fill remaining 7 entries; full shows only after the 8th write edge.
    for (int k = 1; k <= 7; k++)
      cyc($sformatf("fill_%0d", k), 1, 1, 64'h1000 + 64'(k), 11'(16'h10 + k),
          11'(16'h20 + k), 0, 11'h0, 11'h0, 0);
    cyc("wr_9th",      1, 1, 64'h5555, 11'h55, 11'h56, 0, 11'h0, 11'h0, 1);
    cyc("miss_9th",    1, 0, 64'h5555, 11'h0, 11'h0, 0, 11'h0, 11'h0, 1);
    cyc("hit_key0",    1, 0, 64'h4241, 11'h0, 11'h0, 1, 11'h123, 11'h105, 1);
    for (int k = 1; k <= 7; k++)
      cyc($sformatf("hit_fill_%0d", k), 1, 0, 64'h1000 + 64'(k), 11'h0, 11'h0,
          1, 11'(16'h10 + k), 11'(16'h20 + k), 1);

    // Overwrite existing key: old codes visible in write cycle, new after.
    cyc("rewr_1003",   1, 1, 64'h1003, 11'h7FF, 11'h0AA, 1, 11'h13, 11'h23, 1);
    cyc("hit_1003",    1, 0, 64'h1003, 11'h0, 11'h0, 1, 11'h7FF, 11'h0AA, 1);
    cyc("cs0_stored",  0, 0, 64'h1003, 11'h0, 11'h0, 0, 11'h0, 11'h0, 1);

    // Asynchronous reset between edges clears outputs before the next edge.
    @(posedge clk);
    #1;
    rst = 1'b1; cs = 1'b1; we = 1'b0; data = 64'h4241;
    push("async_rst", 0, 11'h0, 11'h0, 0);
    cyc("rst_wr_hold", 1, 1, 64'h4241, 11'h1, 11'h1, 0, 11'h0, 11'h0, 0);
    cyc("rst_hold2",   1, 0, 64'h4241, 11'h0, 11'h0, 0, 11'h0, 11'h0, 0);
    rst = 1'b0;
    cyc("post_rst",    1, 0, 64'h4241, 11'h0, 11'h0, 0, 11'h0, 11'h0, 0);

    // cs=0 blocks writes; rewrite of a present key does not allocate.
    cyc("cs0_write",   0, 1, 64'hABC, 11'h1, 11'h2, 0, 11'h0, 11'h0, 0);
    cyc("cs0_nowr",    1, 0, 64'hABC, 11'h0, 11'h0, 0, 11'h0, 11'h0, 0);
    cyc("wr_abc",      1, 1, 64'hABC, 11'h1, 11'h2, 0, 11'h0, 11'h0, 0);
    cyc("rewr_abc",    1, 1, 64'hABC, 11'h3, 11'h4, 1, 11'h1, 11'h2, 0);
    cyc("hit_abc",     1, 0, 64'hABC, 11'h0, 11'h0, 1, 11'h3, 11'h4, 0);
    for (int k = 1; k <= 6; k++)
      cyc($sformatf("refill_%0d", k), 1, 1, 64'h2000 + 64'(k), 11'(k),
          11'(k + 16'h40), 0, 11'h0, 11'h0, 0);
    cyc("hit_2006",    1, 0, 64'h2006, 11'h0, 11'h0, 1, 11'h6, 11'h46, 0);
    cyc("wr_2007",     1, 1, 64'h2007, 11'h7, 11'h47, 0, 11'h0, 11'h0, 0);
    cyc("hit_2007",    1, 0, 64'h2007, 11'h0, 11'h0, 1, 11'h7, 11'h47, 1);
    cyc("cs0_full",    0, 0, 64'hABC, 11'h0, 11'h0, 0, 11'h0, 11'h0, 1);

    // Drain the scoreboard with a bounded wait.
    for (int i = 0; i < 20 && sb.size() > 0; i++) @(posedge clk);
    if (sb.size() > 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL drain: got %0d pending entries, expected 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
